scoreboard_regfile: RTL and testbench
=====================================

SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 16, data width of every register.
REQ-002 SHALL have parameter NREGS, default 32, number of architectural registers; AW = clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter CNTW, default 2, width of each per-register pending-write counter.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port rd_addr, input, NRD*AW, read address per port.
REQ-008 SHALL have port rd_data, output, NRD*XLEN, read data per port.
REQ-009 SHALL have port rd_busy, output, NRD, pending write outstanding on the addressed register.
REQ-010 SHALL have port iss_valid, input, 1, an instruction writing iss_rd issues this cycle.
REQ-011 SHALL have port iss_rd, input, AW, destination register of the issuing instruction.
REQ-012 SHALL have port iss_ready, output, 1, the issue can be accepted this cycle.
REQ-013 SHALL have port wb_en, input, 1, writeback valid.
REQ-014 SHALL have port wb_addr, input, AW, writeback destination.
REQ-015 SHALL have port wb_data, input, XLEN, writeback value.
REQ-016 SHALL have port flush, input, 1, squash all in-flight writes.

Function
REQ-017 rd_data SHALL be combinational: 0 if address is x0; wb_data if wb_en and wb_addr equals the address and is not x0 (write-first bypass); else the stored value.
REQ-018 A writeback with wb_en=1 and wb_addr!=0 SHALL update the stored register at the clock edge; writes to x0 SHALL be ignored.
REQ-019 Each register SHALL have a CNTW-bit pending counter; x0's counter SHALL stay 0.
REQ-020 An accepted issue (iss_valid & iss_ready, iss_rd!=0) SHALL increment the counter of iss_rd at the edge.
REQ-021 A writeback with wb_addr!=0 SHALL decrement the counter of wb_addr at the edge; a decrement at 0 SHALL leave it at 0 (no underflow).
REQ-022 Same-cycle accepted issue and writeback to the same register SHALL leave its counter unchanged.
REQ-023 iss_ready SHALL be 0 only when iss_rd!=0, its counter equals 2^CNTW-1, and no same-cycle writeback targets iss_rd; otherwise 1.
REQ-024 rd_busy SHALL be 1 when the addressed counter is nonzero, except 0 when the counter is 1 and a same-cycle writeback targets that address; x0 SHALL never be busy.
REQ-025 flush SHALL clear all counters at the edge and take priority over any same-cycle issue; a same-cycle writeback SHALL still update register data.
REQ-026 Issues with iss_valid=1 and iss_ready=0 SHALL have no effect; the issuer holds and retries.

Reset
REQ-027 reset=1 at an edge SHALL clear all registers and all counters to 0, overriding issue, writeback and flush.
REQ-028 During reset, outputs SHALL follow REQ-017/023/024 from the cleared state: rd_busy=0, iss_ready=1, rd_data=0 unless bypassed.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight pending state; later writebacks to zero counters obey REQ-021.

Structure
REQ-030 XLEN default, NREGS default and the register-index width SHALL live in the shared processor package.
REQ-031 The per-register saturating up/down counter SHALL be sub-module sb_counter, instantiated NREGS-1 times.
REQ-032 The register array SHALL be a flop array (no inferred RAM) so bypass and reset hold.

Verification
REQ-033 Reset, then writeback x1=0x00FF, x2=0x00F0 -> next cycle rd_data of x1/x2 = 0x00FF/0x00F0; x0 reads 0 after writeback x0=0x1234.
REQ-034 wb x7=0x000F with rd_addr[0]=7 same cycle -> rd_data[0]=0x000F combinationally before the edge.
REQ-035 Issue x3 three times (CNTW=2) -> rd_busy(x3)=1, iss_ready=0 on a fourth x3 issue; one wb x3 -> counter 2, ready 1 that cycle.
REQ-036 Counter x4=1, same-cycle issue x4 and wb x4=0x000F -> counter stays 1, rd_busy(x4)=1, data 0x000F.
REQ-037 Counters x5=2, x6=1, flush with issue x5 and wb x6=0x00FA -> all busy 0 next cycle, x6=0x00FA; later wb x5 leaves counter 0.
REQ-038 Reset asserted with counters nonzero and wb pending -> all registers 0, all busy 0, iss_ready=1.

Source files
------------

// File: rtl/scoreboard_regfile_pkg.sv
// rtl/scoreboard_regfile_pkg.sv - shared processor constants for the scoreboarded register file
package scoreboard_regfile_pkg;

   // Default data width of every architectural register
   localparam int XLEN_DEF  = 16;
   // Default number of architectural registers (x0 hardwired to zero)
   localparam int NREGS_DEF = 32;
   // Register-index width for the default register count
   localparam int REG_AW    = $clog2(NREGS_DEF);
   // Default width of each pending-write counter
   localparam int CNTW_DEF  = 2;

endpackage

// File: rtl/scoreboard_regfile_if.sv
// rtl/scoreboard_regfile_if.sv - read, issue and writeback bus of the scoreboarded register file
interface scoreboard_regfile_if
   import scoreboard_regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2
);
   localparam int AW = $clog2(NREGS);

   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                iss_valid;
   logic [AW-1:0]       iss_rd;
   logic                iss_ready;
   logic                wb_en;
   logic [AW-1:0]       wb_addr;
   logic [XLEN-1:0]     wb_data;
   logic                flush;

   // Pipeline side: drives addresses, issues and writebacks
   modport master (
      output rd_addr, iss_valid, iss_rd, wb_en, wb_addr, wb_data, flush,
      input  rd_data, rd_busy, iss_ready
   );

   // Register file side
   modport slave (
      input  rd_addr, iss_valid, iss_rd, wb_en, wb_addr, wb_data, flush,
      output rd_data, rd_busy, iss_ready
   );
endinterface

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - saturating up/down pending-write counter for one register
module sb_counter #(
   parameter int CNTW = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clr,
   input  logic            inc,
   input  logic            dec,
   output logic [CNTW-1:0] cnt
);

   // Count issues up and writebacks down; simultaneous inc/dec cancel, clear wins over both
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (inc && !dec) begin
         if (cnt != '1) begin
            cnt <= cnt + CNTW'(1);
         end
      end else if (dec && !inc) begin
         if (cnt != '0) begin
            cnt <= cnt - CNTW'(1);
         end
      end
   end

endmodule

// File: rtl/scoreboard_regfile.sv
// rtl/scoreboard_regfile.sv - flop-based register file with per-register pending-write scoreboard
module scoreboard_regfile
   import scoreboard_regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2,
   parameter int CNTW  = CNTW_DEF
) (
   input logic                  clk,
   input logic                  reset,
   scoreboard_regfile_if.slave  bus
);

   localparam int              AW   = $clog2(NREGS);
   localparam logic [CNTW-1:0] CMAX = '1;

   logic [XLEN-1:0]             regs [NREGS];
   logic [NREGS-1:0][CNTW-1:0]  cnt;
   logic                        wb_live;
   logic                        wb_hits_iss;
   logic                        iss_ok;

   // A writeback only has architectural effect when it targets a real register
   assign wb_live     = bus.wb_en && (bus.wb_addr != '0);
   assign wb_hits_iss = wb_live && (bus.wb_addr == bus.iss_rd);
   assign iss_ok      = bus.iss_valid && bus.iss_ready;

   // Stall issue only when the destination counter is full and nothing drains it this cycle
   assign bus.iss_ready = !((bus.iss_rd != '0) && (cnt[bus.iss_rd] == CMAX) && !wb_hits_iss);

   // x0 never has writes outstanding
   assign cnt[0] = '0;

   generate
      for (genvar i = 1; i < NREGS; i++) begin : g_cnt
         logic inc_i;
         logic dec_i;
         assign inc_i = iss_ok && (bus.iss_rd == AW'(i));
         assign dec_i = bus.wb_en && (bus.wb_addr == AW'(i));
         sb_counter #(.CNTW(CNTW)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (bus.flush),
            .inc   (inc_i),
            .dec   (dec_i),
            .cnt   (cnt[i])
         );
      end
   endgenerate

   // Register storage: reset clears everything, writebacks to x0 are dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_live) begin
         regs[bus.wb_addr] <= bus.wb_data;
      end
   end

   // Read ports with write-first bypass; busy hides a counter that this cycle's writeback retires
   always_comb begin
      bus.rd_data = '0;
      bus.rd_busy = '0;
      for (int p = 0; p < NRD; p++) begin
         logic [AW-1:0]   ra;
         logic [CNTW-1:0] rc;
         logic            hit;
         ra  = bus.rd_addr[p*AW +: AW];
         rc  = cnt[ra];
         hit = bus.wb_en && (bus.wb_addr == ra);
         if (ra == '0) begin
            bus.rd_data[p*XLEN +: XLEN] = '0;
         end else if (hit) begin
            bus.rd_data[p*XLEN +: XLEN] = bus.wb_data;
         end else begin
            bus.rd_data[p*XLEN +: XLEN] = regs[ra];
         end
         bus.rd_busy[p] = (ra != '0) && (rc != '0) && !((rc == CNTW'(1)) && hit);
      end
   end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// tb/tb_scoreboard_regfile.sv - directed self-checking bench for scoreboard_regfile
module tb_scoreboard_regfile;

   localparam int XLEN  = 16;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   scoreboard_regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

   scoreboard_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .CNTW(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.iss_valid = 1'b0;
      bus.wb_en     = 1'b0;
      bus.flush     = 1'b0;
   endtask

   task automatic set_rd(input int p, input logic [AW-1:0] a);
      bus.rd_addr[p*AW +: AW] = a;
   endtask

   task automatic wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      bus.wb_en   = 1'b1;
      bus.wb_addr = a;
      bus.wb_data = d;
   endtask

   task automatic iss(input logic [AW-1:0] a);
      bus.iss_valid = 1'b1;
      bus.iss_rd    = a;
   endtask

   function automatic logic [31:0] d0();
      return 32'(bus.rd_data[XLEN-1:0]);
   endfunction

   function automatic logic [31:0] d1();
      return 32'(bus.rd_data[2*XLEN-1:XLEN]);
   endfunction

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      bus.rd_addr = '0;
      bus.iss_rd  = '0;
      bus.wb_addr = '0;
      bus.wb_data = '0;
      idle();
      set_rd(0, 5'd1);
      set_rd(1, 5'd2);
      tick();
      tick();
      bus.iss_rd = 5'd3;
      #1;
      check("rst_data0", d0(), 32'h0);
      check("rst_busy", 32'(bus.rd_busy), 32'h0);
      check("rst_ready", 32'(bus.iss_ready), 32'h1);
      wb(5'd1, 16'h1111);
      #1;
      check("rst_bypass", d0(), 32'h1111);
      tick();
      idle();
      #1;
      check("rst_wb_dropped", d0(), 32'h0);
      reset = 1'b0;

      // Basic writebacks and x0
      wb(5'd1, 16'h00FF);
      tick();
      wb(5'd2, 16'h00F0);
      tick();
      idle();
      #1;
      check("x1_data", d0(), 32'h00FF);
      check("x2_data", d1(), 32'h00F0);
      wb(5'd0, 16'h1234);
      set_rd(0, 5'd0);
      #1;
      check("x0_no_bypass", d0(), 32'h0);
      tick();
      idle();
      #1;
      check("x0_reads_0", d0(), 32'h0);

      // Write-first bypass
      wb(5'd7, 16'h000F);
      set_rd(0, 5'd7);
      #1;
      check("x7_bypass", d0(), 32'h000F);
      tick();
      idle();
      #1;
      check("x7_stored", d0(), 32'h000F);

      // Fill x3 to saturation
      iss(5'd3);
      set_rd(0, 5'd3);
      #1;
      check("x3_ready_empty", 32'(bus.iss_ready), 32'h1);
      tick();
      tick();
      tick();
      check("x3_ready_full", 32'(bus.iss_ready), 32'h0);
      check("x3_busy", 32'(bus.rd_busy[0]), 32'h1);
      tick();
      bus.iss_valid = 1'b0;
      wb(5'd3, 16'h0033);
      #1;
      check("x3_ready_wb", 32'(bus.iss_ready), 32'h1);
      tick();
      idle();
      #1;
      check("x3_cnt2_busy", 32'(bus.rd_busy[0]), 32'h1);
      check("x3_cnt2_ready", 32'(bus.iss_ready), 32'h1);
      iss(5'd3);
      tick();
      idle();
      #1;
      check("x3_refull", 32'(bus.iss_ready), 32'h0);
      wb(5'd3, 16'h0003);
      tick();
      tick();
      tick();
      tick();
      idle();
      #1;
      check("x3_drained_busy", 32'(bus.rd_busy[0]), 32'h0);
      check("x3_no_underflow", 32'(bus.iss_ready), 32'h1);
      iss(5'd3);
      tick();
      idle();
      #1;
      check("x3_cnt1_busy", 32'(bus.rd_busy[0]), 32'h1);
      wb(5'd3, 16'h0000);
      #1;
      check("x3_cnt1_wb_busy", 32'(bus.rd_busy[0]), 32'h0);
      tick();
      idle();
      #1;
      check("x3_final_busy", 32'(bus.rd_busy[0]), 32'h0);

      // Same-cycle issue and writeback on x4
      iss(5'd4);
      tick();
      wb(5'd4, 16'h000F);
      tick();
      idle();
      set_rd(0, 5'd4);
      #1;
      check("x4_busy", 32'(bus.rd_busy[0]), 32'h1);
      check("x4_data", d0(), 32'h000F);
      wb(5'd4, 16'h0044);
      #1;
      check("x4_busy_wb", 32'(bus.rd_busy[0]), 32'h0);
      tick();
      idle();
      #1;
      check("x4_busy_after", 32'(bus.rd_busy[0]), 32'h0);
      check("x4_data_after", d0(), 32'h0044);

      // Flush with concurrent issue and writeback
      iss(5'd5);
      tick();
      tick();
      iss(5'd6);
      tick();
      idle();
      set_rd(0, 5'd5);
      set_rd(1, 5'd6);
      #1;
      check("pre_flush_busy", 32'(bus.rd_busy), 32'h3);
      bus.flush = 1'b1;
      iss(5'd5);
      wb(5'd6, 16'h00FA);
      tick();
      idle();
      #1;
      check("flush_busy", 32'(bus.rd_busy), 32'h0);
      check("flush_x6_data", d1(), 32'h00FA);
      wb(5'd5, 16'h0055);
      tick();
      idle();
      bus.iss_rd = 5'd5;
      #1;
      check("x5_post_flush_ready", 32'(bus.iss_ready), 32'h1);
      check("x5_post_flush_busy", 32'(bus.rd_busy[0]), 32'h0);
      check("x5_data", d0(), 32'h0055);
      iss(5'd5);
      tick();
      idle();
      #1;
      check("x5_cnt1_busy", 32'(bus.rd_busy[0]), 32'h1);

      // Reset in the middle of activity
      iss(5'd8);
      tick();
      tick();
      tick();
      idle();
      set_rd(0, 5'd8);
      set_rd(1, 5'd1);
      reset = 1'b1;
      wb(5'd8, 16'hABCD);
      iss(5'd9);
      tick();
      idle();
      bus.iss_rd = 5'd8;
      #1;
      check("mid_rst_data8", d0(), 32'h0);
      check("mid_rst_busy8", 32'(bus.rd_busy[0]), 32'h0);
      check("mid_rst_data1", d1(), 32'h0);
      check("mid_rst_ready", 32'(bus.iss_ready), 32'h1);
      set_rd(1, 5'd5);
      #1;
      check("mid_rst_busy5", 32'(bus.rd_busy[1]), 32'h0);
      reset = 1'b0;
      wb(5'd8, 16'h0808);
      tick();
      idle();
      #1;
      check("post_rst_busy8", 32'(bus.rd_busy[0]), 32'h0);
      check("post_rst_ready8", 32'(bus.iss_ready), 32'h1);
      check("post_rst_data8", d0(), 32'h0808);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
